multi_digit_counter: RTL and testbench

- Parametrised successor to the single-digit one-second counter used on the tile.
- Generates a prescaled tick and counts on N cascaded digits in base 10 or 16, up or down.
- Supports synchronous load, pause and a wrap flag.
- Drives a time-multiplexed 7-segment display (uo_out) and exposes the packed count for uio_out.

---
 rtl/counter_disp_pkg.sv | 22 ++
 rtl/seg7_decoder.sv | 11 +
 rtl/multi_digit_counter.sv | 157 +++++++++++++++
 tb/tb_multi_digit_counter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/counter_disp_pkg.sv
// Shared definitions for the multi-digit counter and its 7-segment display path.
package counter_disp_pkg;

  localparam int DIGIT_W = 4;

  // Active-high segment patterns, bit0 = a .. bit6 = g, for 0-9, A, b, C, d, E, F.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic is_max(input logic [DIGIT_W-1:0] digit, input int base);
    return digit == DIGIT_W'(base - 1);
  endfunction

  // Load values above the radix are pinned to the largest legal digit.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] digit,
                                                     input int base);
    return (int'(digit) > base - 1) ? DIGIT_W'(base - 1) : digit;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit code to active-high 7-segment pattern.
module seg7_decoder
  import counter_disp_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic [6:0]         seg
);

  assign seg = SEG_LUT[code];

endmodule

// File: rtl/multi_digit_counter.sv
// Prescaled N-digit up/down counter (base 10 or 16) with load, wrap flag and
// a time-multiplexed 7-segment display driver.
module multi_digit_counter
  import counter_disp_pkg::*;
#(
  parameter int CLK_DIV    = 10_000_000,
  parameter int NUM_DIGITS = 4,
  parameter int BASE       = 10,
  parameter int MUX_DIV    = 10_000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          up_dn,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
  output logic [DIGIT_W*NUM_DIGITS-1:0] count,
  output logic                          tick,
  output logic                          wrap,
  output logic [6:0]                    seg,
  output logic [NUM_DIGITS-1:0]         dig_sel
);

  localparam int CW = DIGIT_W * NUM_DIGITS;
  localparam int PW = $clog2(CLK_DIV);
  localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_TC   = PW'(CLK_DIV - 1);
  localparam logic [MW-1:0] MUX_TC   = MW'(MUX_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]      presc;
  logic               presc_tc;
  logic               step;
  logic [CW-1:0]      count_nxt;
  logic [CW-1:0]      load_clamped;
  logic               all_roll;
  logic [MW-1:0]      refresh;
  logic [IW-1:0]      mux_idx;
  logic [DIGIT_W-1:0] mux_digit;
  logic [6:0]         seg_dec;

  assign presc_tc = (presc == PRE_TC);
  // A load in the terminal-count cycle wins over the step, but tick still fires.
  assign step     = en && presc_tc && !load;

  // Prescaler and registered tick; load restarts the tick period.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= en && presc_tc;
      if (load)
        presc <= '0;
      else if (en)
        presc <= presc_tc ? '0 : presc + 1'b1;
    end
  end

  // Ripple carry/borrow chain; cout of the last digit means the whole counter rolled.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [DIGIT_W-1:0] cur;
    logic [DIGIT_W-1:0] nxt;
    logic               cin;
    logic               cout;

    assign cur = count[DIGIT_W*i +: DIGIT_W];

    if (i == 0) begin : g_first
      assign cin = 1'b1;
    end else begin : g_chain
      assign cin = g_digit[i-1].cout;
    end

    // Next value of this digit given the incoming carry/borrow.
    always_comb begin
      nxt  = cur;
      cout = 1'b0;
      if (cin) begin
        if (up_dn) begin
          if (is_max(cur, BASE)) begin
            nxt  = '0;
            cout = 1'b1;
          end else begin
            nxt = cur + 1'b1;
          end
        end else begin
          if (cur == '0) begin
            nxt  = DIGIT_W'(BASE - 1);
            cout = 1'b1;
          end else begin
            nxt = cur - 1'b1;
          end
        end
      end
    end

    assign count_nxt[DIGIT_W*i +: DIGIT_W]    = nxt;
    assign load_clamped[DIGIT_W*i +: DIGIT_W] = clamp_digit(load_val[DIGIT_W*i +: DIGIT_W], BASE);
  end

  assign all_roll = g_digit[NUM_DIGITS-1].cout;

  // Digit register with load priority; wrap pulses with a full roll-over/under.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= step && all_roll;
      if (load)
        count <= load_clamped;
      else if (step)
        count <= count_nxt;
    end
  end

  // Display refresh timer and digit index, free-running regardless of en/load.
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh <= '0;
      mux_idx <= '0;
    end else if (refresh == MUX_TC) begin
      refresh <= '0;
      mux_idx <= (mux_idx == IDX_LAST) ? '0 : mux_idx + 1'b1;
    end else begin
      refresh <= refresh + 1'b1;
    end
  end

  // Select the digit currently being displayed.
  always_comb begin
    mux_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (mux_idx == IW'(i))
        mux_digit = count[DIGIT_W*i +: DIGIT_W];
    end
  end

  seg7_decoder u_dec (
    .code (mux_digit),
    .seg  (seg_dec)
  );

  // Segment pattern and digit enable registered together so they never disagree.
  always_ff @(posedge clk) begin
    if (reset) begin
      dig_sel <= NUM_DIGITS'(1);
      seg     <= SEG_LUT[0];
    end else begin
      dig_sel <= NUM_DIGITS'(1) << mux_idx;
      seg     <= seg_dec;
    end
  end

endmodule

// File: tb/tb_multi_digit_counter.sv
// Directed bench: a BASE=10 and a BASE=16 counter share all stimulus.
module tb_multi_digit_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [7:0] load_val;

  logic [7:0] count10, count16;
  logic       tick10, tick16, wrap10, wrap16;
  logic [6:0] seg10, seg16;
  logic [1:0] dig_sel10, dig_sel16;

  int checks = 0;
  int errors = 0;

  multi_digit_counter #(.CLK_DIV(4), .NUM_DIGITS(2), .BASE(10), .MUX_DIV(2)) u_dut10 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(count10), .tick(tick10), .wrap(wrap10), .seg(seg10), .dig_sel(dig_sel10)
  );

  multi_digit_counter #(.CLK_DIV(4), .NUM_DIGITS(2), .BASE(16), .MUX_DIV(2)) u_dut16 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(count16), .tick(tick16), .wrap(wrap16), .seg(seg16), .dig_sel(dig_sel16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_count10", 32'(count10), 32'h00);
    chk("rst_tick10", 32'(tick10), 32'h0);
    chk("rst_wrap10", 32'(wrap10), 32'h0);
    chk("rst_dig_sel10", 32'(dig_sel10), 32'h1);
    chk("rst_seg10", 32'(seg10), 32'h3F);
    chk("rst_count16", 32'(count16), 32'h00);
    chk("rst_dig_sel16", 32'(dig_sel16), 32'h1);
  endtask

  initial begin
    logic [7:0] exp_bcd;
    logic [1:0] prev_sel;
    logic [6:0] exp_seg;
    int         n;
    int         run;
    int         changes;

    reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00;
    step(); step();
    chk_reset_state();

    // Free count up through a decade carry.
    reset = 1'b0; en = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      step();
      n = c / 4;
      exp_bcd = 8'(((n / 10) * 16) + (n % 10));
      chk("up_tick", 32'(tick10), 32'(c % 4 == 0));
      chk("up_count10", 32'(count10), 32'(exp_bcd));
      chk("up_count16", 32'(count16), 32'(n));
      chk("up_wrap10", 32'(wrap10), 32'h0);
    end

    // Roll-over from 99.
    load = 1'b1; load_val = 8'h99;
    step();
    load = 1'b0;
    chk("ld99_count10", 32'(count10), 32'h99);
    chk("ld99_tick", 32'(tick10), 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("ld99_notick", 32'(tick10), 32'h0);
      chk("ld99_hold", 32'(count10), 32'h99);
    end
    step();
    chk("ovf_tick", 32'(tick10), 32'h1);
    chk("ovf_count10", 32'(count10), 32'h00);
    chk("ovf_wrap10", 32'(wrap10), 32'h1);
    chk("ovf_count16", 32'(count16), 32'h9A);
    chk("ovf_wrap16", 32'(wrap16), 32'h0);
    step();
    chk("ovf_wrap10_pulse", 32'(wrap10), 32'h0);
    chk("ovf_count10_after", 32'(count10), 32'h00);

    // Roll-under from 00, both radices.
    up_dn = 1'b0; load = 1'b1; load_val = 8'h00;
    step();
    load = 1'b0;
    chk("ld00_count10", 32'(count10), 32'h00);
    chk("ld00_count16", 32'(count16), 32'h00);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("ld00_notick", 32'(tick10), 32'h0);
    end
    step();
    chk("unf_tick", 32'(tick10), 32'h1);
    chk("unf_count10", 32'(count10), 32'h99);
    chk("unf_wrap10", 32'(wrap10), 32'h1);
    chk("unf_count16", 32'(count16), 32'hFF);
    chk("unf_wrap16", 32'(wrap16), 32'h1);
    step();
    chk("unf_wrap10_pulse", 32'(wrap10), 32'h0);
    chk("unf_wrap16_pulse", 32'(wrap16), 32'h0);

    // Load coinciding with the terminal-count cycle.
    up_dn = 1'b1;
    step(); step();
    load = 1'b1; load_val = 8'h37;
    step();
    load = 1'b0;
    chk("ldtick_tick", 32'(tick10), 32'h1);
    chk("ldtick_count10", 32'(count10), 32'h37);
    chk("ldtick_wrap10", 32'(wrap10), 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("ldtick_notick", 32'(tick10), 32'h0);
      chk("ldtick_hold", 32'(count10), 32'h37);
    end
    step();
    chk("ldtick_next_tick", 32'(tick10), 32'h1);
    chk("ldtick_next_count", 32'(count10), 32'h38);

    // Clamp of an out-of-range decimal digit; load mid-period restarts the prescaler.
    step(); step();
    load = 1'b1; load_val = 8'hC5;
    step();
    load = 1'b0;
    chk("clamp_count10", 32'(count10), 32'h95);
    chk("clamp_count16", 32'(count16), 32'hC5);
    chk("clamp_tick", 32'(tick10), 32'h0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("presc_restart_notick", 32'(tick10), 32'h0);
    end
    step();
    chk("presc_restart_tick", 32'(tick10), 32'h1);
    chk("clamp_next10", 32'(count10), 32'h96);
    chk("clamp_next16", 32'(count16), 32'hC6);

    // Display multiplexing on a frozen count.
    en = 1'b0; load = 1'b1; load_val = 8'h42;
    step();
    load = 1'b0;
    step(); step();
    prev_sel = dig_sel10;
    run = 0;
    changes = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("hold_count10", 32'(count10), 32'h42);
      chk("hold_tick", 32'(tick10), 32'h0);
      exp_seg = (dig_sel10 == 2'b01) ? 7'h5B : (dig_sel10 == 2'b10) ? 7'h66 : 7'h00;
      chk("mux_seg", 32'(seg10), 32'(exp_seg));
      if (dig_sel10 != prev_sel) begin
        if (changes > 0)
          chk("mux_period", 32'(run), 32'd2);
        changes++;
        run = 1;
        prev_sel = dig_sel10;
      end else begin
        run++;
      end
      chk("mux_hold_max", 32'(run <= 2), 32'h1);
    end
    chk("mux_toggles", 32'(changes >= 9), 32'h1);

    // Reset in the middle of counting.
    en = 1'b1;
    step(); step();
    reset = 1'b1;
    step();
    chk_reset_state();
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
